down_counter_timer: RTL and testbench

DOWN_COUNTER_TIMER -- requirements
Module: down_counter_timer

---
 rtl/down_counter_timer.sv | 99 +++++++++
 tb/tb_down_counter_timer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/down_counter_timer.sv
// Loadable down-counter timer with IDLE/RUN control and a one-cycle done pulse.
// Define DOWN_COUNTER_TIMER_AUTORELOAD_EN to reload and keep running at terminal count.
module down_counter_timer #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             start,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             zero
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // Next-state and registered-output logic; load always beats start
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (load) begin
               count_d  = load_value;
               reload_d = load_value;
            end else if (start) begin
               if (count_q != '0) state_d = RUN;
               else               done_d  = 1'b1;
            end
         end
         RUN: begin
            if (load) begin
               count_d  = load_value;
               reload_d = load_value;
               state_d  = IDLE;
            end else if (enable) begin
               if (count_q > WIDTH'(1)) begin
                  count_d = count_q - WIDTH'(1);
               end else if (count_q == WIDTH'(1)) begin
                  done_d = 1'b1;
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
                  if (reload_q != '0) begin
                     count_d = reload_q;
                  end else begin
                     count_d = '0;
                     state_d = IDLE;
                  end
`else
                  count_d = '0;
                  state_d = IDLE;
`endif
               end else begin
                  // Unreachable: RUN is never entered with a zero count
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN);
   end

   assign count = count_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign zero  = (count_q == '0);

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed self-checking bench for down_counter_timer (default and autoreload builds).
module tb_down_counter_timer;

   localparam int unsigned WIDTH = 4;

   logic             clk;
   logic             reset;
   logic             enable;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic             start;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;
   logic             zero;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   down_counter_timer #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .load       (load),
      .load_value (load_value),
      .start      (start),
      .count      (count),
      .busy       (busy),
      .done       (done),
      .zero       (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] c, input logic b,
                          input logic d, input logic z);
      chk({tag, ".count"}, 8'(count), c);
      chk({tag, ".busy"},  8'(busy),  8'(b));
      chk({tag, ".done"},  8'(done),  8'(d));
      chk({tag, ".zero"},  8'(zero),  8'(z));
   endtask

   initial begin
      reset = 1'b0; enable = 1'b0; load = 1'b0; load_value = '0; start = 1'b0;
      #2 reset = 1'b1;
      #1 chk_all("reset_async", 8'd0, 1'b0, 1'b0, 1'b1);
      tick(); tick();
      reset = 1'b0;

      // Basic countdown from 3
      load = 1'b1; load_value = 4'd3;
      tick(); chk_all("basic_load", 8'd3, 1'b0, 1'b0, 1'b0);
      load = 1'b0; start = 1'b1; enable = 1'b1;
      tick(); chk_all("basic_start", 8'd3, 1'b1, 1'b0, 1'b0);
      start = 1'b0;
      tick(); chk_all("basic_c2", 8'd2, 1'b1, 1'b0, 1'b0);
      tick(); chk_all("basic_c1", 8'd1, 1'b1, 1'b0, 1'b0);
      tick();
      if (AR) chk_all("basic_term", 8'd3, 1'b1, 1'b1, 1'b0);
      else    chk_all("basic_term", 8'd0, 1'b0, 1'b1, 1'b1);
      load = 1'b1; load_value = 4'd0;
      tick(); chk_all("basic_after", 8'd0, 1'b0, 1'b0, 1'b1);
      load = 1'b0;

      // Pause: enable low for 3 cycles after first decrement
      load = 1'b1; load_value = 4'd4;
      tick(); chk_all("pause_load", 8'd4, 1'b0, 1'b0, 1'b0);
      load = 1'b0; start = 1'b1; enable = 1'b1;
      tick(); chk_all("pause_start", 8'd4, 1'b1, 1'b0, 1'b0);
      start = 1'b0;
      tick(); chk_all("pause_c3", 8'd3, 1'b1, 1'b0, 1'b0);
      enable = 1'b0;
      tick(); chk_all("pause_h1", 8'd3, 1'b1, 1'b0, 1'b0);
      tick(); chk_all("pause_h2", 8'd3, 1'b1, 1'b0, 1'b0);
      tick(); chk_all("pause_h3", 8'd3, 1'b1, 1'b0, 1'b0);
      enable = 1'b1;
      tick(); chk_all("pause_c2", 8'd2, 1'b1, 1'b0, 1'b0);
      tick(); chk_all("pause_c1", 8'd1, 1'b1, 1'b0, 1'b0);
      tick();
      if (AR) chk_all("pause_term", 8'd4, 1'b1, 1'b1, 1'b0);
      else    chk_all("pause_term", 8'd0, 1'b0, 1'b1, 1'b1);
      load = 1'b1; load_value = 4'd0;
      tick(); chk_all("pause_after", 8'd0, 1'b0, 1'b0, 1'b1);
      load = 1'b0;

      // Abort: load with start at count 6 loads 9, returns IDLE, no done
      load = 1'b1; load_value = 4'd6;
      tick();
      load = 1'b0; start = 1'b1;
      tick(); chk_all("abort_run6", 8'd6, 1'b1, 1'b0, 1'b0);
      load = 1'b1; load_value = 4'd9; start = 1'b1;
      tick(); chk_all("abort_load9", 8'd9, 1'b0, 1'b0, 1'b0);
      load = 1'b0; start = 1'b0;
      tick(); chk_all("abort_idle", 8'd9, 1'b0, 1'b0, 1'b0);

      // Start held in RUN is ignored; countdown to 5 then async reset
      start = 1'b1;
      tick(); chk_all("run_start9", 8'd9, 1'b1, 1'b0, 1'b0);
      tick(); chk_all("run_ign_start", 8'd8, 1'b1, 1'b0, 1'b0);
      start = 1'b0;
      tick(); tick(); tick();
      chk_all("run_c5", 8'd5, 1'b1, 1'b0, 1'b0);
      #1 reset = 1'b1;
      #1 chk_all("reset_midrun", 8'd0, 1'b0, 1'b0, 1'b1);
      tick();
      reset = 1'b0;
      tick(); chk_all("post_reset1", 8'd0, 1'b0, 1'b0, 1'b1);
      tick(); chk_all("post_reset2", 8'd0, 1'b0, 1'b0, 1'b1);

      // Zero start: done pulse, never busy
      load = 1'b1; load_value = 4'd0;
      tick();
      load = 1'b0; start = 1'b1;
      tick(); chk_all("zero_start", 8'd0, 1'b0, 1'b1, 1'b1);
      start = 1'b0;
      tick(); chk_all("zero_after", 8'd0, 1'b0, 1'b0, 1'b1);

      // Load and start together in IDLE: load wins
      load = 1'b1; start = 1'b1; load_value = 4'd2;
      tick(); chk_all("idle_ld_st", 8'd2, 1'b0, 1'b0, 1'b0);
      load = 1'b0; start = 1'b0;

`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
      // Autoreload from 2 over 8 edges
      start = 1'b1; enable = 1'b1;
      tick(); chk_all("ar_start", 8'd2, 1'b1, 1'b0, 1'b0);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick(); chk_all("ar_c1", 8'd1, 1'b1, 1'b0, 1'b0);
         tick(); chk_all("ar_reload", 8'd2, 1'b1, 1'b1, 1'b0);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
